// File: rtl/rx_fifo.sv
// rx_fifo: synchronous first-word-fall-through receive FIFO.
// It buffers bytes from rx_engine until the bus side pops them. It reports
// the fill level, full/empty, a programmable threshold flag, and sticky
// overrun/underflow flags. There is no back-pressure toward the writer,
// so a write that arrives while the FIFO is full is dropped and flagged.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wen_i,
    input  logic             ren_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o,
    input  logic [CW-1:0]    thresh_i,
    output logic             thresh_hit_o,
    input  logic             flush_i,
    output logic             overrun_o,
    output logic             underflow_o,
    input  logic             err_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Storage (not reset) plus read/write pointers that wrap at DEPTH
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             underflow_q, underflow_d;

    // Handshake qualifiers for this cycle
    logic wr_accept;
    logic pop_accept;
    logic ovr_set;
    logic udf_set;

    // Status is decoded from the registered count, so it is glitch-free
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == DEPTH_C);
    assign count_o      = count_q;
    assign thresh_hit_o = (thresh_i != '0) && (count_q >= thresh_i);
    assign overrun_o    = overrun_q;
    assign underflow_o  = underflow_q;

    // The head of the queue is driven directly from the array (fall-through)
    assign rd_data_o = mem_q[rd_ptr_q];

    // Decide which strobes are honoured. Flush masks everything. A write
    // while full is still allowed when a pop frees the slot in the same
    // cycle. A pop while empty is never allowed, even if a write lands in
    // that same cycle.
    always_comb begin
        wr_accept  = 1'b0;
        pop_accept = 1'b0;
        ovr_set    = 1'b0;
        udf_set    = 1'b0;
        if (!flush_i) begin
            wr_accept  = wen_i && (!full_o || ren_i);
            pop_accept = ren_i && !empty_o;
            ovr_set    = wen_i && full_o && !ren_i;
            udf_set    = ren_i && empty_o;
        end
    end

    // Next-state for pointers, count and sticky error flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        underflow_d = underflow_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_accept) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_accept, pop_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A new error event in this cycle wins over a clear request
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (err_clr_i) begin
            overrun_d = 1'b0;
        end

        if (udf_set) begin
            underflow_d = 1'b1;
        end else if (err_clr_i) begin
            underflow_d = 1'b0;
        end
    end

    // Control state register; reset has priority over everything
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            underflow_q <= underflow_d;
        end
    end

    // Data array write. Contents are not cleared by reset or flush, because
    // the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed self-checking bench for rx_fifo.
// A table of single-cycle vectors is followed by hand-written multi-cycle
// sequences: fill/drain, overrun, full simultaneous access, threshold with
// pointer wrap, flush, and reset in the middle of operation.
module tb_rx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wen;
    logic       ren;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic [4:0] thresh;
    logic       thresh_hit;
    logic       flush;
    logic       overrun;
    logic       underflow;
    logic       err_clr;

    int checks = 0;
    int errors = 0;

    rx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .wr_data_i    (wr_data),
        .wen_i        (wen),
        .ren_i        (ren),
        .rd_data_o    (rd_data),
        .empty_o      (empty),
        .full_o       (full),
        .count_o      (count),
        .thresh_i     (thresh),
        .thresh_hit_o (thresh_hit),
        .flush_i      (flush),
        .overrun_o    (overrun),
        .underflow_o  (underflow),
        .err_clr_i    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wen;
        logic       ren;
        logic       flush;
        logic       clr;
        logic [7:0] data;
        logic [4:0] thresh;
        int         exp_count;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_th;
        logic       exp_ov;
        logic       exp_uf;
        logic       chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive the strobes for one clock. Outputs are then sampled 1 time unit
    // after the active edge.
    task automatic step(input logic w, input logic r, input logic f,
                        input logic c, input logic [7:0] d);
        @(negedge clk);
        wen     = w;
        ren     = r;
        flush   = f;
        err_clr = c;
        wr_data = d;
        @(posedge clk);
        #1;
        wen     = 1'b0;
        ren     = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] nextval;
        int         mcount;

        reset   = 1'b1;
        wen     = 1'b0;
        ren     = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        wr_data = 8'h00;
        thresh  = 5'd0;

        // Vector table: wen ren flush clr data thresh | count empty full th ov uf chk_rd rd
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h11,5'd2, 1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h11};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,8'h22,5'd2, 2,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,8'h11};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,5'd2, 1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h22};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,8'h44,5'd2, 1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h44};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,5'd2, 0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,5'd2, 0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,8'h00,5'd2, 0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,8'h33,5'd2, 1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,8'h33};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,8'h00,5'd2, 0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,8'h00,5'd2, 0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,8'h00,5'd2, 0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,8'h5A,5'd0, 1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h5A};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,8'h6B,5'd0, 2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h5A};
        vecs[13] = '{1'b1,1'b1,1'b1,1'b0,8'h99,5'd0, 0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b0,8'h7E,5'd0, 1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h7E};
        vecs[15] = '{1'b0,1'b1,1'b0,1'b0,8'h00,5'd0, 0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};

        // Reset: hold for 5 cycles and check the idle state
        do_reset(5);
        chk("reset count", int'(count), 0);
        chk("reset empty", int'(empty), 1);
        chk("reset full", int'(full), 0);
        chk("reset thresh_hit", int'(thresh_hit), 0);
        chk("reset overrun", int'(overrun), 0);
        chk("reset underflow", int'(underflow), 0);
        $display("txn reset: count=%0d empty=%0b", count, empty);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 16; i++) begin
            thresh = vecs[i].thresh;
            step(vecs[i].wen, vecs[i].ren, vecs[i].flush, vecs[i].clr, vecs[i].data);
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d empty", i), int'(empty), int'(vecs[i].exp_empty));
            chk($sformatf("vec%0d full", i), int'(full), int'(vecs[i].exp_full));
            chk($sformatf("vec%0d thresh_hit", i), int'(thresh_hit), int'(vecs[i].exp_th));
            chk($sformatf("vec%0d overrun", i), int'(overrun), int'(vecs[i].exp_ov));
            chk($sformatf("vec%0d underflow", i), int'(underflow), int'(vecs[i].exp_uf));
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d rd_data", i), int'(rd_data), int'(vecs[i].exp_rd));
            $display("txn vec%0d: wen=%0b ren=%0b flush=%0b clr=%0b data=%02h -> count=%0d rd=%02h",
                     i, vecs[i].wen, vecs[i].ren, vecs[i].flush, vecs[i].clr,
                     vecs[i].data, count, rd_data);
        end

        // Ordered fill/drain; the threshold at DEPTH is hit only when full
        thresh = 5'd16;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            chk($sformatf("fill%0d count", i), int'(count), i + 1);
            chk($sformatf("fill%0d full", i), int'(full), (i == 15) ? 1 : 0);
            chk($sformatf("fill%0d thresh_hit", i), int'(thresh_hit), (i == 15) ? 1 : 0);
            $display("txn fill write %02h count=%0d", i, count);
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d rd_data", i), int'(rd_data), i);
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            $display("txn drain pop count=%0d", count);
        end
        chk("drain empty", int'(empty), 1);
        chk("drain count", int'(count), 0);

        // Overrun: a write into a full FIFO is dropped and flagged
        thresh = 5'd0;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        chk("ovr overrun", int'(overrun), 1);
        chk("ovr count", int'(count), 16);
        chk("ovr underflow", int'(underflow), 0);
        $display("txn overrun write AA: overrun=%0b count=%0d", overrun, count);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovr clear", int'(overrun), 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovr drain%0d rd_data", i), int'(rd_data), 8'h10 + i);
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        chk("ovr drain empty", int'(empty), 1);
        $display("txn overrun drain done: empty=%0b", empty);

        // Full with simultaneous write and pop: count holds and 0x55 lands last
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h20 + i));
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        chk("simfull count", int'(count), 16);
        chk("simfull full", int'(full), 1);
        chk("simfull overrun", int'(overrun), 0);
        chk("simfull rd_data", int'(rd_data), 8'h21);
        $display("txn full wen+ren 55: count=%0d rd=%02h", count, rd_data);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("simfull drain%0d", i), int'(rd_data), 8'h20 + i);
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        chk("simfull last", int'(rd_data), 8'h55);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("simfull empty", int'(empty), 1);

        // Threshold and pointer wrap: count oscillates 3..5 over 40 operations
        thresh  = 5'd4;
        nextval = 8'h80;
        mcount  = 0;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, nextval);
            q.push_back(nextval);
            nextval++;
            mcount++;
        end
        for (int i = 0; i < 40; i++) begin
            if ((i % 4) == 0 || (i % 4) == 3) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, nextval);
                q.push_back(nextval);
                nextval++;
                mcount++;
            end else begin
                chk($sformatf("wrap%0d rd_data", i), int'(rd_data), int'(q[0]));
                void'(q.pop_front());
                step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
                mcount--;
            end
            chk($sformatf("wrap%0d count", i), int'(count), mcount);
            chk($sformatf("wrap%0d thresh_hit", i), int'(thresh_hit), (mcount >= 4) ? 1 : 0);
            $display("txn wrap op%0d: count=%0d thresh_hit=%0b", i, count, thresh_hit);
        end
        while (q.size() > 0) begin
            chk("wrap tail rd_data", int'(rd_data), int'(q[0]));
            void'(q.pop_front());
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        chk("wrap tail empty", int'(empty), 1);

        // Flush with a sticky flag already set: the flag must survive
        thresh = 5'd0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("flush pre underflow", int'(underflow), 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hC0 + i));
        chk("flush pre count", int'(count), 5);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
        chk("flush count", int'(count), 0);
        chk("flush empty", int'(empty), 1);
        chk("flush underflow kept", int'(underflow), 1);
        chk("flush overrun kept", int'(overrun), 0);
        $display("txn flush: count=%0d empty=%0b underflow=%0b", count, empty, underflow);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h7E);
        chk("flush readback", int'(rd_data), 8'h7E);
        chk("flush readback count", int'(count), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("flush clr underflow", int'(underflow), 0);

        // Reset in mid-operation, with a write strobe present, discards everything
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
        @(negedge clk);
        reset   = 1'b1;
        wen     = 1'b1;
        wr_data = 8'h03;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wen   = 1'b0;
        chk("midreset count", int'(count), 0);
        chk("midreset empty", int'(empty), 1);
        $display("txn midreset: count=%0d empty=%0b", count, empty);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
